soc_reset_sequencer: RTL and testbench
======================================

# soc_reset_sequencer

Reset sequencer that sits directly downstream of the SoC control register block. It consumes that block's watchdog-expiry and soft-reset request pulses and turns them into ordered reset outputs: peripheral reset first, fabric-controller core reset released later. It also keeps a reset-cause code and a saturating reset counter that firmware can read back.

## Interface
Parameters:
- ASSERT_CYCLES, 16, number of cycles both resets are held asserted (legal range 1..2^CNT_WIDTH-1)
- CORE_DELAY, 8, cycles between peripheral release and core release (legal range 1..2^CNT_WIDTH-1)
- CNT_WIDTH, 8, width of the internal sequencing counter

Ports:
- HCLK  in  1  system clock; one clock only
- HRESET  in  1  asynchronous, active-high reset
- wd_expired_i  in  1  watchdog expiry request, rising-edge triggered
- soft_reset_i  in  1  software reset request, rising-edge triggered
- cause_clr_i  in  1  single-cycle pulse that clears the cause code
- periph_rst_o  out  1  peripheral reset, active-high
- core_rst_o  out  1  fabric-controller core reset, active-high
- cause_o  out  2  last reset cause: 00 cleared, 01 POR, 10 watchdog, 11 soft
- rst_count_o  out  8  number of triggered sequences since HRESET, saturates at 255
- busy_o  out  1  high whenever the state is not IDLE

## Operation
- States:
  - HOLD: periph_rst_o=1, core_rst_o=1.
  - PREL: periph_rst_o=0, core_rst_o=1.
  - IDLE: both resets 0.
- Reset values while HRESET=1: state HOLD, counter=ASSERT_CYCLES-1, periph_rst_o=1, core_rst_o=1, cause_o=01, rst_count_o=0, busy_o=1, edge-detect registers=0.
- HOLD: the counter decrements each cycle. At 0 the block moves to PREL and loads the counter with CORE_DELAY-1.
- PREL: the counter decrements each cycle. At 0 the block moves to IDLE.
- IDLE, trigger detected: move to HOLD, load the counter with ASSERT_CYCLES-1, set cause_o, increment rst_count_o (saturating).
- Both triggers on the same cycle: watchdog wins, cause_o=10, rst_count_o increments by 1 only.
- Triggers seen in HOLD or PREL are discarded. A discarded trigger does not change the cause code or the counter, and it is not replayed later.
- cause_clr_i sets cause_o to 00, but only in IDLE. If a trigger arrives on the same cycle, the trigger wins.
- Triggering is on rising edges only: an input held high produces exactly one sequence.
- HRESET asserted mid-sequence aborts the sequence and forces the reset values above. POR cause overrides any other cause.
- Outputs are driven directly from registers. There are no combinational paths from inputs to outputs.

## Timing
- Without the sync option: a rising edge sampled on HCLK edge N causes periph_rst_o=1, core_rst_o=1 and busy_o=1 after edge N (1-cycle latency).
- With the sync option: the same response appears 2 cycles later (3-cycle latency).
- periph_rst_o stays high for exactly ASSERT_CYCLES cycles.
- core_rst_o stays high for exactly ASSERT_CYCLES+CORE_DELAY cycles.
- busy_o falls on the same edge as core_rst_o.
- After HRESET deasserts: periph_rst_o falls after ASSERT_CYCLES edges, core_rst_o falls after ASSERT_CYCLES+CORE_DELAY edges.
- cause_o and rst_count_o update on the same edge that enters HOLD.
- The earliest re-trigger is accepted on the first cycle in IDLE.

## Configuration
- SOC_RST_SYNC_EN defined:
  - wd_expired_i and soft_reset_i each pass through a 2-flop synchronizer before edge detection, so they may come from ref_clk or other asynchronous domains.
  - Synchronizer flops reset to 0.
  - Input pulses must be at least 2 HCLK cycles wide.
- SOC_RST_SYNC_EN undefined:
  - Inputs go straight into single-register edge detection.
  - Inputs must be synchronous to HCLK; a 1-cycle pulse is sufficient.

## Test plan
All scenarios use the defaults (ASSERT_CYCLES=16, CORE_DELAY=8) unless noted.
- POR: release HRESET -> periph_rst_o falls after 16 edges, core_rst_o after 24, cause_o=01, rst_count_o=0, busy_o falls with core_rst_o.
- Soft reset: 1-cycle soft_reset_i pulse in IDLE (no macro) -> resets high 1 cycle later, periph_rst_o high 16 cycles, core_rst_o high 24 cycles, cause_o=11, rst_count_o=1.
- Simultaneous triggers: wd_expired_i and soft_reset_i rise on the same cycle -> cause_o=10, rst_count_o increments by exactly 1.
- Mid-sequence triggers:
  - wd_expired_i pulse during HOLD, then soft_reset_i held high for 40 cycles -> one sequence only, cause unchanged by the discarded pulse.
  - cause_clr_i in IDLE -> cause_o=00.
- Saturation and abort: 300 spaced triggers -> rst_count_o stops at 255. HRESET asserted during PREL -> immediate return to reset values, cause_o=01.
- SOC_RST_SYNC_EN defined: a 2-cycle-wide wd_expired_i pulse -> periph_rst_o high 3 cycles after the sampled rise; a 1-cycle-wide pulse is not required to be detected.

Source files
------------

// File: rtl/soc_reset_sequencer.sv
// Ordered reset sequencer: peripheral reset released first, core reset CORE_DELAY cycles later.
// Define SOC_RST_SYNC_EN to pass the request inputs through 2-flop synchronizers.
module soc_reset_sequencer #(
  parameter int ASSERT_CYCLES = 16,
  parameter int CORE_DELAY    = 8,
  parameter int CNT_WIDTH     = 8
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       wd_expired_i,
  input  logic       soft_reset_i,
  input  logic       cause_clr_i,
  output logic       periph_rst_o,
  output logic       core_rst_o,
  output logic [1:0] cause_o,
  output logic [7:0] rst_count_o,
  output logic       busy_o
);

  localparam logic [CNT_WIDTH-1:0] LP_HOLD_LOAD = CNT_WIDTH'(ASSERT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LP_PREL_LOAD = CNT_WIDTH'(CORE_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] LP_CNT_ZERO  = CNT_WIDTH'(0);
  localparam logic [CNT_WIDTH-1:0] LP_CNT_ONE   = CNT_WIDTH'(1);

  localparam logic [1:0] LP_CAUSE_CLR  = 2'b00;
  localparam logic [1:0] LP_CAUSE_POR  = 2'b01;
  localparam logic [1:0] LP_CAUSE_WD   = 2'b10;
  localparam logic [1:0] LP_CAUSE_SOFT = 2'b11;

  typedef enum logic [1:0] {
    ST_HOLD = 2'b00,
    ST_PREL = 2'b01,
    ST_IDLE = 2'b10
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;
  logic [1:0]            r_cause;
  logic [1:0]            w_cause_nxt;
  logic [7:0]            r_rst_count;
  logic [7:0]            w_rst_count_nxt;
  logic                  r_periph;
  logic                  r_core;
  logic                  r_busy;
  logic                  w_wd_lvl;
  logic                  w_soft_lvl;
  logic                  r_wd_prev;
  logic                  r_soft_prev;
  logic                  w_wd_rise;
  logic                  w_soft_rise;

`ifdef SOC_RST_SYNC_EN
  logic [1:0] r_wd_sync;
  logic [1:0] r_soft_sync;

  // Two-stage synchronizers for requests arriving from other clock domains
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_wd_sync   <= 2'b00;
      r_soft_sync <= 2'b00;
    end else begin
      r_wd_sync   <= {r_wd_sync[0], wd_expired_i};
      r_soft_sync <= {r_soft_sync[0], soft_reset_i};
    end
  end

  assign w_wd_lvl   = r_wd_sync[1];
  assign w_soft_lvl = r_soft_sync[1];
`else
  assign w_wd_lvl   = wd_expired_i;
  assign w_soft_lvl = soft_reset_i;
`endif

  // Edge-detect history registers
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_wd_prev   <= 1'b0;
      r_soft_prev <= 1'b0;
    end else begin
      r_wd_prev   <= w_wd_lvl;
      r_soft_prev <= w_soft_lvl;
    end
  end

  assign w_wd_rise   = w_wd_lvl & ~r_wd_prev;
  assign w_soft_rise = w_soft_lvl & ~r_soft_prev;

  // Next-state, counter, cause and reset-count logic
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_cause_nxt     = r_cause;
    w_rst_count_nxt = r_rst_count;
    case (r_state)
      ST_HOLD: begin
        if (r_cnt == LP_CNT_ZERO) begin
          w_state_nxt = ST_PREL;
          w_cnt_nxt   = LP_PREL_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - LP_CNT_ONE;
        end
      end
      ST_PREL: begin
        if (r_cnt == LP_CNT_ZERO) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - LP_CNT_ONE;
        end
      end
      ST_IDLE: begin
        // A new trigger outranks a same-cycle cause clear; watchdog outranks soft reset
        if (w_wd_rise || w_soft_rise) begin
          w_state_nxt     = ST_HOLD;
          w_cnt_nxt       = LP_HOLD_LOAD;
          w_cause_nxt     = w_wd_rise ? LP_CAUSE_WD : LP_CAUSE_SOFT;
          w_rst_count_nxt = (r_rst_count == 8'hFF) ? r_rst_count : (r_rst_count + 8'd1);
        end else if (cause_clr_i) begin
          w_cause_nxt = LP_CAUSE_CLR;
        end else begin
          w_cause_nxt = r_cause;
        end
      end
      default: begin
        w_state_nxt = ST_HOLD;
        w_cnt_nxt   = LP_HOLD_LOAD;
      end
    endcase
  end

  // State, counter and status registers; outputs registered from next state
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state     <= ST_HOLD;
      r_cnt       <= LP_HOLD_LOAD;
      r_cause     <= LP_CAUSE_POR;
      r_rst_count <= 8'd0;
      r_periph    <= 1'b1;
      r_core      <= 1'b1;
      r_busy      <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cause     <= w_cause_nxt;
      r_rst_count <= w_rst_count_nxt;
      r_periph    <= (w_state_nxt == ST_HOLD);
      r_core      <= (w_state_nxt != ST_IDLE);
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  assign periph_rst_o = r_periph;
  assign core_rst_o   = r_core;
  assign cause_o      = r_cause;
  assign rst_count_o  = r_rst_count;
  assign busy_o       = r_busy;

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Self-checking bench for soc_reset_sequencer: expected cause/count pushed on stimulus, popped on response.
module tb_soc_reset_sequencer;

  localparam int A = 16;
  localparam int D = 8;
`ifdef SOC_RST_SYNC_EN
  localparam int LAT = 3;
  localparam int PW  = 2;
`else
  localparam int LAT = 1;
  localparam int PW  = 1;
`endif

  logic       HCLK;
  logic       HRESET;
  logic       wd_expired_i;
  logic       soft_reset_i;
  logic       cause_clr_i;
  logic       periph_rst_o;
  logic       core_rst_o;
  logic [1:0] cause_o;
  logic [7:0] rst_count_o;
  logic       busy_o;

  typedef struct packed {
    logic [1:0] cause;
    logic [7:0] count;
  } exp_t;

  exp_t sb_q[$];
  int   model_cnt = 0;
  int   n_checks  = 0;
  int   n_errors  = 0;

  soc_reset_sequencer #(.ASSERT_CYCLES(A), .CORE_DELAY(D), .CNT_WIDTH(8)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .wd_expired_i(wd_expired_i), .soft_reset_i(soft_reset_i),
    .cause_clr_i(cause_clr_i), .periph_rst_o(periph_rst_o), .core_rst_o(core_rst_o),
    .cause_o(cause_o), .rst_count_o(rst_count_o), .busy_o(busy_o)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] c);
    if (model_cnt < 255) model_cnt++;
    sb_q.push_back({c, 8'(model_cnt)});
  endtask

  // An empty queue yields X fields, so any compare against it fails
  task automatic pop_exp(output exp_t e);
    if (sb_q.size() == 0) e = 'x;
    else e = sb_q.pop_front();
  endtask

  // Drives a trigger and returns at the sample where the response should be visible
  task automatic fire(input logic wd, input logic sf, input logic clr);
    for (int k = 0; k < LAT; k++) begin
      wd_expired_i = (k < PW) ? wd : 1'b0;
      soft_reset_i = (k < PW) ? sf : 1'b0;
      cause_clr_i  = (k == LAT - 1) ? clr : 1'b0;
      tick();
    end
    wd_expired_i = 1'b0;
    soft_reset_i = 1'b0;
    cause_clr_i  = 1'b0;
  endtask

  task automatic measure(output int p, output int c, output int bb, output bit to);
    int n;
    p = 0; c = 0; bb = 0; n = 0;
    while ((periph_rst_o === 1'b1 || core_rst_o === 1'b1) && n < 200) begin
      if (periph_rst_o === 1'b1) p++;
      if (core_rst_o === 1'b1) c++;
      if (busy_o !== core_rst_o) bb++;
      tick();
      n++;
    end
    if (busy_o !== 1'b0) bb++;
    to = (n >= 200);
  endtask

  task automatic test_reset();
    int p, c, bb; bit to;
    HRESET = 1'b1; wd_expired_i = 1'b0; soft_reset_i = 1'b0; cause_clr_i = 1'b0;
    repeat (3) tick();
    n_checks++; if (periph_rst_o !== 1'b1) begin n_errors++; $display("FAIL por_periph: got %b want 1", periph_rst_o); end
    n_checks++; if (core_rst_o !== 1'b1) begin n_errors++; $display("FAIL por_core: got %b want 1", core_rst_o); end
    n_checks++; if (busy_o !== 1'b1) begin n_errors++; $display("FAIL por_busy: got %b want 1", busy_o); end
    n_checks++; if (cause_o !== 2'b01) begin n_errors++; $display("FAIL por_cause: got %b want 01", cause_o); end
    n_checks++; if (rst_count_o !== 8'd0) begin n_errors++; $display("FAIL por_count: got %0d want 0", rst_count_o); end
    HRESET = 1'b0;
    model_cnt = 0;
    measure(p, c, bb, to);
    n_checks++; if (p !== A) begin n_errors++; $display("FAIL por_periph_len: got %0d want %0d", p, A); end
    n_checks++; if (c !== A + D) begin n_errors++; $display("FAIL por_core_len: got %0d want %0d", c, A + D); end
    n_checks++; if (bb !== 0 || to) begin n_errors++; $display("FAIL por_busy_track: got %0d errs timeout=%0b want 0", bb, to); end
    n_checks++; if (cause_o !== 2'b01) begin n_errors++; $display("FAIL por_cause_after: got %b want 01", cause_o); end
  endtask

  task automatic test_soft();
    int p, c, bb; bit to; exp_t e;
    push_exp(2'b11);
    fire(1'b0, 1'b1, 1'b0);
    pop_exp(e);
    n_checks++; if ({periph_rst_o, core_rst_o, busy_o} !== 3'b111) begin n_errors++; $display("FAIL soft_latency: got %b want 111", {periph_rst_o, core_rst_o, busy_o}); end
    n_checks++; if (cause_o !== e.cause) begin n_errors++; $display("FAIL soft_cause: got %b want %b", cause_o, e.cause); end
    n_checks++; if (rst_count_o !== e.count) begin n_errors++; $display("FAIL soft_count: got %0d want %0d", rst_count_o, e.count); end
    measure(p, c, bb, to);
    n_checks++; if (p !== A) begin n_errors++; $display("FAIL soft_periph_len: got %0d want %0d", p, A); end
    n_checks++; if (c !== A + D) begin n_errors++; $display("FAIL soft_core_len: got %0d want %0d", c, A + D); end
    n_checks++; if (bb !== 0 || to) begin n_errors++; $display("FAIL soft_busy_track: got %0d errs timeout=%0b want 0", bb, to); end
  endtask

  task automatic test_simultaneous();
    int p, c, bb; bit to; exp_t e;
    push_exp(2'b10);
    fire(1'b1, 1'b1, 1'b0);
    pop_exp(e);
    n_checks++; if (periph_rst_o !== 1'b1) begin n_errors++; $display("FAIL simul_latency: got %b want 1", periph_rst_o); end
    n_checks++; if (cause_o !== e.cause) begin n_errors++; $display("FAIL simul_cause: got %b want %b", cause_o, e.cause); end
    n_checks++; if (rst_count_o !== e.count) begin n_errors++; $display("FAIL simul_count: got %0d want %0d", rst_count_o, e.count); end
    measure(p, c, bb, to);
    n_checks++; if (p !== A || c !== A + D || to) begin n_errors++; $display("FAIL simul_len: got %0d/%0d want %0d/%0d", p, c, A, A + D); end
  endtask

  task automatic test_mid_sequence();
    int p, c, bb, seen, highs; bit to, prev; exp_t e;
    push_exp(2'b11);
    fire(1'b0, 1'b1, 1'b0);
    pop_exp(e);
    n_checks++; if (cause_o !== e.cause || rst_count_o !== e.count) begin n_errors++; $display("FAIL mid_first: got %b/%0d want %b/%0d", cause_o, rst_count_o, e.cause, e.count); end
    for (int k = 0; k < PW; k++) begin
      wd_expired_i = 1'b1;
      tick();
    end
    wd_expired_i = 1'b0;
    measure(p, c, bb, to);
    n_checks++; if (p !== A - PW || c !== A + D - PW || to) begin n_errors++; $display("FAIL mid_len: got %0d/%0d want %0d/%0d", p, c, A - PW, A + D - PW); end
    n_checks++; if (cause_o !== 2'b11) begin n_errors++; $display("FAIL mid_discard_cause: got %b want 11", cause_o); end
    n_checks++; if (rst_count_o !== 8'(model_cnt)) begin n_errors++; $display("FAIL mid_discard_count: got %0d want %0d", rst_count_o, model_cnt); end
    highs = 0;
    repeat (10) begin
      tick();
      if (periph_rst_o !== 1'b0) highs++;
    end
    n_checks++; if (highs !== 0) begin n_errors++; $display("FAIL mid_no_replay: got %0d high cycles want 0", highs); end
    push_exp(2'b11);
    soft_reset_i = 1'b1;
    seen = 0; prev = 1'b0;
    for (int k = 0; k < 70; k++) begin
      if (k == 40) soft_reset_i = 1'b0;
      tick();
      if (periph_rst_o === 1'b1 && !prev) begin
        seen++;
        pop_exp(e);
        n_checks++; if (cause_o !== e.cause || rst_count_o !== e.count) begin n_errors++; $display("FAIL held_resp: got %b/%0d want %b/%0d", cause_o, rst_count_o, e.cause, e.count); end
      end
      prev = periph_rst_o;
    end
    n_checks++; if (seen !== 1) begin n_errors++; $display("FAIL held_one_seq: got %0d sequences want 1", seen); end
    n_checks++; if (rst_count_o !== 8'(model_cnt)) begin n_errors++; $display("FAIL held_count: got %0d want %0d", rst_count_o, model_cnt); end
  endtask

  task automatic test_cause_clr();
    int n; exp_t e;
    cause_clr_i = 1'b1;
    tick();
    cause_clr_i = 1'b0;
    n_checks++; if (cause_o !== 2'b00) begin n_errors++; $display("FAIL clr_idle: got %b want 00", cause_o); end
    n_checks++; if (busy_o !== 1'b0 || rst_count_o !== 8'(model_cnt)) begin n_errors++; $display("FAIL clr_side_effect: busy %b count %0d want 0/%0d", busy_o, rst_count_o, model_cnt); end
    push_exp(2'b10);
    fire(1'b1, 1'b0, 1'b1);
    pop_exp(e);
    n_checks++; if (cause_o !== e.cause) begin n_errors++; $display("FAIL clr_vs_trigger: got %b want %b", cause_o, e.cause); end
    n_checks++; if (rst_count_o !== e.count) begin n_errors++; $display("FAIL clr_trig_count: got %0d want %0d", rst_count_o, e.count); end
    cause_clr_i = 1'b1;
    tick();
    cause_clr_i = 1'b0;
    n_checks++; if (cause_o !== 2'b10) begin n_errors++; $display("FAIL clr_in_hold: got %b want 10", cause_o); end
    n = 0;
    while (busy_o === 1'b1 && n < 100) begin tick(); n++; end
    n_checks++; if (n >= 100) begin n_errors++; $display("FAIL clr_idle_timeout: got busy after %0d cycles want idle", n); end
  endtask

  task automatic test_back_to_back();
    int p, c, bb; bit to; exp_t e;
    push_exp(2'b11);
    fire(1'b0, 1'b1, 1'b0);
    pop_exp(e);
    n_checks++; if (cause_o !== e.cause || rst_count_o !== e.count) begin n_errors++; $display("FAIL b2b_first: got %b/%0d want %b/%0d", cause_o, rst_count_o, e.cause, e.count); end
    measure(p, c, bb, to);
    push_exp(2'b10);
    fire(1'b1, 1'b0, 1'b0);
    pop_exp(e);
    n_checks++; if (periph_rst_o !== 1'b1) begin n_errors++; $display("FAIL b2b_retrigger: got %b want 1", periph_rst_o); end
    n_checks++; if (cause_o !== e.cause || rst_count_o !== e.count) begin n_errors++; $display("FAIL b2b_second: got %b/%0d want %b/%0d", cause_o, rst_count_o, e.cause, e.count); end
    measure(p, c, bb, to);
    n_checks++; if (p !== A || c !== A + D || bb !== 0 || to) begin n_errors++; $display("FAIL b2b_len: got %0d/%0d want %0d/%0d", p, c, A, A + D); end
  endtask

  task automatic test_saturation();
    int n; exp_t e; bit w;
    for (int i = 0; i < 300; i++) begin
      w = (i % 2 == 1);
      push_exp(w ? 2'b10 : 2'b11);
      fire(w, ~w, 1'b0);
      pop_exp(e);
      n_checks++; if (cause_o !== e.cause || rst_count_o !== e.count) begin n_errors++; $display("FAIL sat_step%0d: got %b/%0d want %b/%0d", i, cause_o, rst_count_o, e.cause, e.count); end
      n = 0;
      while (busy_o === 1'b1 && n < 100) begin tick(); n++; end
      if (n >= 100) begin n_checks++; n_errors++; $display("FAIL sat_timeout: got busy at step %0d want idle", i); end
    end
    n_checks++; if (rst_count_o !== 8'd255) begin n_errors++; $display("FAIL sat_final: got %0d want 255", rst_count_o); end
  endtask

  task automatic test_abort();
    int p, c, bb; bit to; exp_t e;
    push_exp(2'b11);
    fire(1'b0, 1'b1, 1'b0);
    pop_exp(e);
    n_checks++; if (cause_o !== e.cause || rst_count_o !== e.count) begin n_errors++; $display("FAIL abort_trig: got %b/%0d want %b/%0d", cause_o, rst_count_o, e.cause, e.count); end
    repeat (A) tick();
    n_checks++; if ({periph_rst_o, core_rst_o} !== 2'b01) begin n_errors++; $display("FAIL abort_in_prel: got %b want 01", {periph_rst_o, core_rst_o}); end
    HRESET = 1'b1;
    #1;
    model_cnt = 0;
    n_checks++; if ({periph_rst_o, core_rst_o, busy_o} !== 3'b111) begin n_errors++; $display("FAIL abort_resets: got %b want 111", {periph_rst_o, core_rst_o, busy_o}); end
    n_checks++; if (cause_o !== 2'b01) begin n_errors++; $display("FAIL abort_cause: got %b want 01", cause_o); end
    n_checks++; if (rst_count_o !== 8'd0) begin n_errors++; $display("FAIL abort_count: got %0d want 0", rst_count_o); end
    tick();
    HRESET = 1'b0;
    measure(p, c, bb, to);
    n_checks++; if (p !== A || c !== A + D || bb !== 0 || to) begin n_errors++; $display("FAIL abort_rerelease: got %0d/%0d want %0d/%0d", p, c, A, A + D); end
  endtask

  initial begin
    test_reset();
    test_soft();
    test_simultaneous();
    test_mid_sequence();
    test_cause_clr();
    test_back_to_back();
    test_saturation();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
